// File: rtl/g76_pkg.sv
// Shared types and screen geometry for the pixel request queue.
package g76_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;

    typedef struct packed {
        logic       write;
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] data;
    } pixel_cmd_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_WAIT = 2'd1,
        READ_WAIT  = 2'd2
    } queue_state_t;

    // Unsigned bounds check against the visible screen area.
    function automatic logic in_range(input pixel_cmd_t c);
        return (c.x < 9'(SCREEN_WIDTH)) && (c.y < 8'(SCREEN_HEIGHT));
    endfunction

endpackage

// File: rtl/pixel_cmd_fifo.sv
// Synchronous FIFO of pixel commands; wrapping pointers plus a separate
// occupancy counter so full/empty never depend on pointer comparison.
module pixel_cmd_fifo
    import g76_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  pixel_cmd_t    i_cmd,
    input  logic          i_pop,
    output pixel_cmd_t    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    pixel_cmd_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_cmd;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_request_queue.sv
// Buffers host pixel commands and replays them one at a time onto the
// memory manager's request/complete handshake, with range and timeout traps.
module pixel_request_queue
    import g76_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         hostValid,
    output logic                         hostReady,
    input  logic                         hostWrite,
    input  logic [8:0]                   hostX,
    input  logic [7:0]                   hostY,
    input  logic [7:0]                   hostData,
    output logic [7:0]                   readData,
    output logic                         readDataValid,
    output logic                         readError,
    output logic                         rangeError,
    output logic                         timeoutError,
    input  logic                         clearErrors,
    output logic [$clog2(DEPTH+1)-1:0]   queueCount,
    output logic [8:0]                   memoryXCoord,
    output logic [7:0]                   memoryYCoord,
    output logic [7:0]                   memoryWriteData,
    output logic                         memoryWriteRequest,
    output logic                         memoryReadRequest,
    input  logic [7:0]                   memoryReadData,
    input  logic                         memoryReadComplete,
    input  logic                         memoryWriteComplete
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    queue_state_t r_state;
    logic [TW-1:0] r_timer;
    pixel_cmd_t   w_head;
    pixel_cmd_t   w_host_cmd;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_done;
    logic         w_expired;
    logic         w_range_set;
    logic         w_timeout_set;

    assign w_host_cmd = '{write: hostWrite, x: hostX, y: hostY, data: hostData};
    assign hostReady  = !w_full;

    // Only pop while idle, so request always spends one low cycle between commands.
    assign w_pop         = (r_state == IDLE) && !w_empty;
    assign w_done        = ((r_state == WRITE_WAIT) && memoryWriteComplete) ||
                           ((r_state == READ_WAIT)  && memoryReadComplete);
    assign w_expired     = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_range_set   = w_pop && !in_range(w_head);
    assign w_timeout_set = (r_state != IDLE) && !w_done && w_expired;

    pixel_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (hostValid),
        .i_cmd   (w_host_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queueCount)
    );

    // Issue FSM: latch head on pop, hold request until completion or timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= IDLE;
            r_timer            <= '0;
            memoryXCoord       <= '0;
            memoryYCoord       <= '0;
            memoryWriteData    <= '0;
            memoryWriteRequest <= 1'b0;
            memoryReadRequest  <= 1'b0;
            readData           <= '0;
            readDataValid      <= 1'b0;
            readError          <= 1'b0;
            rangeError         <= 1'b0;
            timeoutError       <= 1'b0;
        end else begin
            readDataValid <= 1'b0;
            readError     <= 1'b0;
            // A new error on the same edge as clearErrors keeps the flag set.
            rangeError    <= (rangeError && !clearErrors) || w_range_set;
            timeoutError  <= (timeoutError && !clearErrors) || w_timeout_set;

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        memoryXCoord    <= w_head.x;
                        memoryYCoord    <= w_head.y;
                        memoryWriteData <= w_head.data;
                        r_timer         <= '0;
                        if (in_range(w_head)) begin
                            if (w_head.write) begin
                                memoryWriteRequest <= 1'b1;
                                r_state            <= WRITE_WAIT;
                            end else begin
                                memoryReadRequest <= 1'b1;
                                r_state           <= READ_WAIT;
                            end
                        end else if (!w_head.write) begin
                            readDataValid <= 1'b1;
                            readError     <= 1'b1;
                            readData      <= '0;
                        end
                    end
                end
                WRITE_WAIT: begin
                    if (memoryWriteComplete || w_expired) begin
                        memoryWriteRequest <= 1'b0;
                        r_state            <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                READ_WAIT: begin
                    if (memoryReadComplete) begin
                        readData          <= memoryReadData;
                        readDataValid     <= 1'b1;
                        memoryReadRequest <= 1'b0;
                        r_state           <= IDLE;
                    end else if (w_expired) begin
                        readData          <= '0;
                        readDataValid     <= 1'b1;
                        readError         <= 1'b1;
                        memoryReadRequest <= 1'b0;
                        r_state           <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    memoryWriteRequest <= 1'b0;
                    memoryReadRequest  <= 1'b0;
                    r_state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_request_queue.sv
// Directed bench for pixel_request_queue with a transaction-level reference model.
module tb_pixel_request_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hostValid = 1'b0;
    logic       hostReady;
    logic       hostWrite = 1'b0;
    logic [8:0] hostX = '0;
    logic [7:0] hostY = '0;
    logic [7:0] hostData = '0;
    logic [7:0] readData;
    logic       readDataValid;
    logic       readError;
    logic       rangeError;
    logic       timeoutError;
    logic       clearErrors = 1'b0;
    logic [3:0] queueCount;
    logic [8:0] memoryXCoord;
    logic [7:0] memoryYCoord;
    logic [7:0] memoryWriteData;
    logic       memoryWriteRequest;
    logic       memoryReadRequest;
    logic [7:0] memoryReadData = '0;
    logic       memoryReadComplete = 1'b0;
    logic       memoryWriteComplete = 1'b0;

    int errors = 0;
    int checks = 0;

    // memory responder knobs
    bit       resp_en = 1'b0;
    int       lat = 2;
    logic [7:0] rd_val = 8'h00;

    pixel_request_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .hostValid(hostValid), .hostReady(hostReady), .hostWrite(hostWrite),
        .hostX(hostX), .hostY(hostY), .hostData(hostData),
        .readData(readData), .readDataValid(readDataValid), .readError(readError),
        .rangeError(rangeError), .timeoutError(timeoutError), .clearErrors(clearErrors),
        .queueCount(queueCount),
        .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
        .memoryWriteData(memoryWriteData),
        .memoryWriteRequest(memoryWriteRequest), .memoryReadRequest(memoryReadRequest),
        .memoryReadData(memoryReadData),
        .memoryReadComplete(memoryReadComplete), .memoryWriteComplete(memoryWriteComplete)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory manager stand-in: completes a request once it has been high for lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clock);
            memoryWriteComplete = 1'b0;
            memoryReadComplete  = 1'b0;
            if (!reset) cnt = 0;
            else if (memoryWriteRequest || memoryReadRequest) begin
                cnt++;
                if (resp_en && cnt >= lat) begin
                    memoryWriteComplete = memoryWriteRequest;
                    memoryReadComplete  = memoryReadRequest;
                    memoryReadData      = rd_val;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    // Reference model: a queue of pending commands plus the one in flight.
    typedef struct {
        logic       w;
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } mcmd_t;

    mcmd_t mq[$];

    initial begin
        mcmd_t cur, c;
        bit    busy, push, set_rng, set_to;
        int    age;
        logic  e_rv, e_re, e_rng, e_to;
        logic [7:0] e_rd;
        busy = 0; age = 0; e_rv = 0; e_re = 0; e_rd = 0; e_rng = 0; e_to = 0;
        cur = '{0, 0, 0, 0};
        forever begin
            @(posedge clock);
            if (!reset) begin
                mq.delete();
                busy = 0; age = 0; e_rv = 0; e_re = 0; e_rng = 0; e_to = 0;
            end else begin
                push = hostValid && (mq.size() < DEPTH);
                e_rv = 0; e_re = 0; set_rng = 0; set_to = 0;
                if (busy) begin
                    if (cur.w ? memoryWriteComplete : memoryReadComplete) begin
                        busy = 0;
                        if (!cur.w) begin e_rv = 1; e_rd = memoryReadData; end
                    end else if (age == TIMEOUT - 1) begin
                        busy = 0; set_to = 1;
                        if (!cur.w) begin e_rv = 1; e_re = 1; e_rd = 0; end
                    end else age++;
                end else if (mq.size() > 0) begin
                    c = mq.pop_front();
                    if (c.x < 320 && c.y < 240) begin
                        busy = 1; age = 0; cur = c;
                    end else begin
                        set_rng = 1;
                        if (!c.w) begin e_rv = 1; e_re = 1; e_rd = 0; end
                    end
                end
                if (push) mq.push_back('{hostWrite, hostX, hostY, hostData});
                e_rng = (e_rng && !clearErrors) || set_rng;
                e_to  = (e_to && !clearErrors) || set_to;
            end
            #1;
            chk("m_ready", hostReady, mq.size() < DEPTH);
            chk("m_count", queueCount, mq.size());
            chk("m_wreq", memoryWriteRequest, busy && cur.w);
            chk("m_rreq", memoryReadRequest, busy && !cur.w);
            chk("m_rvalid", readDataValid, e_rv);
            chk("m_rerr", readError, e_re);
            chk("m_rng", rangeError, e_rng);
            chk("m_to", timeoutError, e_to);
            if (e_rv) chk("m_rdata", readData, e_rd);
            if (busy) begin
                chk("m_x", memoryXCoord, cur.x);
                chk("m_y", memoryYCoord, cur.y);
                if (cur.w) chk("m_wdata", memoryWriteData, cur.d);
            end
        end
    end

    task automatic push_cmd(input bit w, input int x, input int y, input int d);
        @(negedge clock);
        hostValid = 1'b1;
        hostWrite = w;
        hostX = 9'(x);
        hostY = 8'(y);
        hostData = 8'(d);
        @(negedge clock);
        hostValid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (i < bound && !(queueCount == 0 && !memoryWriteRequest && !memoryReadRequest)) begin
            @(negedge clock);
            i++;
        end
        chk("idle_reached", (queueCount == 0 && !memoryWriteRequest && !memoryReadRequest), 1);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        int n;
        repeat (3) @(negedge clock);
        chk("rst_ready", hostReady, 1);
        chk("rst_count", queueCount, 0);
        chk("rst_wreq", memoryWriteRequest, 0);
        chk("rst_rreq", memoryReadRequest, 0);
        chk("rst_rvalid", readDataValid, 0);
        chk("rst_flags", {rangeError, timeoutError}, 0);
        chk("rst_x", memoryXCoord, 0);
        reset = 1'b1;

        // single write, completion after 3 cycles
        resp_en = 1; lat = 3;
        push_cmd(1, 5, 7, 8'hA5);
        @(negedge clock);
        chk("w1_req", memoryWriteRequest, 1);
        chk("w1_x", memoryXCoord, 5);
        chk("w1_y", memoryYCoord, 7);
        chk("w1_d", memoryWriteData, 8'hA5);
        repeat (2) @(negedge clock);
        chk("w1_req_held", memoryWriteRequest, 1);
        @(negedge clock);
        chk("w1_req_low", memoryWriteRequest, 0);
        chk("w1_count", queueCount, 0);

        // fill: one in flight plus eight queued
        resp_en = 0;
        for (int i = 0; i < 9; i++) push_cmd(1, i, 10 + i, 8'h10 + i);
        chk("full_count", queueCount, 8);
        chk("full_ready", hostReady, 0);
        push_cmd(1, 100, 100, 8'hEE);
        chk("full_reject", queueCount, 8);
        lat = 2; resp_en = 1;
        wait_idle(300);

        // in-range read at the far corner
        rd_val = 8'h3C;
        push_cmd(0, 319, 239, 0);
        for (int i = 0; i < 20 && !readDataValid; i++) @(negedge clock);
        chk("rd_valid", readDataValid, 1);
        chk("rd_data", readData, 8'h3C);
        chk("rd_err", readError, 0);

        // range traps
        push_cmd(1, 320, 0, 8'h11);
        @(negedge clock);
        chk("rng_w_flag", rangeError, 1);
        chk("rng_w_noreq", memoryWriteRequest, 0);
        push_cmd(0, 0, 240, 0);
        @(negedge clock);
        chk("rng_r_valid", readDataValid, 1);
        chk("rng_r_err", readError, 1);
        chk("rng_r_data", readData, 0);
        chk("rng_r_noreq", memoryReadRequest, 0);
        clearErrors = 1;
        @(negedge clock);
        clearErrors = 0;
        chk("rng_clear", rangeError, 0);
        // clear on the same edge as a new range error: set wins
        push_cmd(1, 400, 0, 0);
        clearErrors = 1;
        @(negedge clock);
        clearErrors = 0;
        chk("rng_set_wins", rangeError, 1);
        clearErrors = 1;
        @(negedge clock);
        clearErrors = 0;

        // timeout on a read, with a write queued behind it
        resp_en = 0;
        push_cmd(0, 10, 10, 0);
        push_cmd(1, 1, 1, 8'h55);
        chk("to_req_up", memoryReadRequest, 1);
        n = 2;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!memoryReadRequest) break;
            n++;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_flag", timeoutError, 1);
        chk("to_valid", readDataValid, 1);
        chk("to_err", readError, 1);
        chk("to_data", readData, 0);
        lat = 1; resp_en = 1;
        @(negedge clock);
        chk("to_next_req", memoryWriteRequest, 1);
        chk("to_next_x", memoryXCoord, 1);
        wait_idle(50);
        clearErrors = 1;
        @(negedge clock);
        clearErrors = 0;
        chk("to_clear", timeoutError, 0);

        // reset mid-read with three queued
        resp_en = 0;
        push_cmd(0, 20, 20, 0);
        for (int i = 0; i < 3; i++) push_cmd(1, 30 + i, 30, 8'h40 + i);
        chk("rstm_count", queueCount, 3);
        chk("rstm_rreq", memoryReadRequest, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstm_drop", memoryReadRequest, 0);
        chk("rstm_cnt0", queueCount, 0);
        chk("rstm_norv", readDataValid, 0);
        chk("rstm_ready", hostReady, 1);
        @(negedge clock);
        reset = 1'b1;
        lat = 2; resp_en = 1;
        push_cmd(1, 7, 8, 8'h99);
        @(negedge clock);
        chk("resume_req", memoryWriteRequest, 1);
        chk("resume_x", memoryXCoord, 7);
        wait_idle(50);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
